// File: rtl/el2_pkg.sv
// el2_pkg: shared types and SECDED code definition for the ICCM ECC correction block
package el2_pkg;
  localparam int ICCM_ECC_LEG_W = 39;
  localparam int ICCM_DATA_W = 32;
  localparam int ICCM_ECC_W = 7;
  typedef enum logic [1:0] {IDLE, PEND, WB} el2_iccm_corr_state_t;
  // Hsiao columns: the 32 smallest weight-3 7-bit values, column i belongs to data bit i
  function automatic logic [ICCM_DATA_W*ICCM_ECC_W-1:0] hsiao_cols();
    int n;
    n = 0;
    hsiao_cols = '0;
    for (int v = 0; v < 128; v++)
      if ($countones(v[6:0]) == 3 && n < ICCM_DATA_W) begin
        hsiao_cols[n*ICCM_ECC_W +: ICCM_ECC_W] = v[6:0];
        n++;
      end
  endfunction
  localparam logic [ICCM_DATA_W*ICCM_ECC_W-1:0] HSIAO_H = hsiao_cols();
endpackage

// File: rtl/el2_iccm_secded39_dec.sv
// el2_iccm_secded39_dec: combinational Hsiao SECDED check and single-bit correction of one 39-bit leg
module el2_iccm_secded39_dec
  import el2_pkg::*;
(
  input  logic [ICCM_ECC_LEG_W-1:0] din,
  output logic [ICCM_DATA_W-1:0]    dout,
  output logic [ICCM_ECC_W-1:0]     eout,
  output logic                      single_err,
  output logic                      double_err
);
  logic [ICCM_ECC_W-1:0] syn;
  always_comb begin
    syn = din[ICCM_ECC_LEG_W-1:ICCM_DATA_W];
    for (int i = 0; i < ICCM_DATA_W; i++)
      syn ^= din[i] ? HSIAO_H[i*ICCM_ECC_W +: ICCM_ECC_W] : '0;
    single_err = (|syn) & (^syn);
    double_err = (|syn) & ~(^syn);
    dout = din[ICCM_DATA_W-1:0];
    eout = din[ICCM_ECC_LEG_W-1:ICCM_DATA_W];
    for (int i = 0; i < ICCM_DATA_W; i++)
      dout[i] = din[i] ^ (single_err && syn == HSIAO_H[i*ICCM_ECC_W +: ICCM_ECC_W]);
    for (int j = 0; j < ICCM_ECC_W; j++)
      eout[j] = din[ICCM_DATA_W+j] ^ (single_err && syn == 7'(1 << j));
  end
endmodule

// File: rtl/el2_ifu_iccm_ecc_corr.sv
// el2_ifu_iccm_ecc_corr: ICCM read SECDED check and single-error write-back sequencer.
// RV_ICCM_ECC_ERR_CNT_EN builds the saturating single/drop error counters.
module el2_ifu_iccm_ecc_corr
  import el2_pkg::*;
#(
  parameter int ICCM_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iccm_rd_vld,
  input  logic                  iccm_rd_hi_vld,
  input  logic [ICCM_BITS-1:1]  iccm_rd_addr_q,
  input  logic [77:0]           iccm_rd_data_ecc,
  input  logic                  corr_gnt,
  output logic                  corr_req,
  output logic                  iccm_correction_state,
  output logic                  iccm_buf_correct_ecc,
  output logic                  iccm_corr_wren,
  output logic [ICCM_BITS-1:1]  iccm_corr_addr,
  output logic [2:0]            iccm_corr_wr_size,
  output logic [77:0]           iccm_corr_wr_data,
  output logic                  ecc_sb_err,
  output logic                  ecc_db_err,
  output logic                  ecc_err_drop,
  output logic [15:0]           ecc_sb_cnt,
  output logic [15:0]           ecc_drop_cnt
);
  localparam int AW = ICCM_BITS - 2;
  el2_iccm_corr_state_t state, state_nxt;
  logic [ICCM_DATA_W-1:0] lo_d, hi_d;
  logic [ICCM_ECC_W-1:0] lo_e, hi_e;
  logic lo_s, lo_db, hi_s, hi_db;
  logic db, lo_sb, hi_sb, cap;
  logic [1:0] n_sb, n_drop;
  logic [AW-1:0] lo_wa, hi_wa, cap_wa;
  logic [ICCM_ECC_LEG_W-1:0] cap_word;
  logic unused_addr_lsb;
  el2_iccm_secded39_dec u_lo (
    .din(iccm_rd_data_ecc[38:0]), .dout(lo_d), .eout(lo_e),
    .single_err(lo_s), .double_err(lo_db)
  );
  el2_iccm_secded39_dec u_hi (
    .din(iccm_rd_data_ecc[77:39]), .dout(hi_d), .eout(hi_e),
    .single_err(hi_s), .double_err(hi_db)
  );
  assign unused_addr_lsb = iccm_rd_addr_q[1];
  assign lo_wa = iccm_rd_addr_q[ICCM_BITS-1:2];
  assign hi_wa = lo_wa + 1'b1;
  // any double on a checked leg suppresses single handling of the whole read
  always_comb begin
    db = iccm_rd_vld & (lo_db | (iccm_rd_hi_vld & hi_db));
    lo_sb = iccm_rd_vld & ~db & lo_s;
    hi_sb = iccm_rd_vld & ~db & iccm_rd_hi_vld & hi_s;
    n_sb = {1'b0, lo_sb} + {1'b0, hi_sb};
    cap = (state == IDLE) & (lo_sb | hi_sb);
    n_drop = cap ? {1'b0, lo_sb & hi_sb} : n_sb;
    state_nxt = (state == IDLE) ? (cap ? PEND : IDLE) :
                (state == PEND) ? (corr_gnt ? WB : PEND) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cap_word <= '0;
      cap_wa <= '0;
      ecc_sb_err <= 1'b0;
      ecc_db_err <= 1'b0;
      ecc_err_drop <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        cap_word <= lo_sb ? {lo_e, lo_d} : {hi_e, hi_d};
        cap_wa <= lo_sb ? lo_wa : hi_wa;
      end
      ecc_sb_err <= |n_sb;
      ecc_db_err <= db;
      ecc_err_drop <= ecc_err_drop | (|n_drop);
    end
  end
  assign corr_req = state == PEND;
  assign iccm_correction_state = state != IDLE;
  assign iccm_buf_correct_ecc = state == WB;
  assign iccm_corr_wren = iccm_buf_correct_ecc;
  assign iccm_corr_addr = {cap_wa, 1'b0};
  assign iccm_corr_wr_size = 3'b010;
  assign iccm_corr_wr_data = {cap_word, cap_word};
`ifdef RV_ICCM_ECC_ERR_CNT_EN
  logic [16:0] sb_sum, drop_sum;
  always_comb begin
    sb_sum = {1'b0, ecc_sb_cnt} + {15'd0, n_sb};
    drop_sum = {1'b0, ecc_drop_cnt} + {15'd0, n_drop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ecc_sb_cnt <= '0;
      ecc_drop_cnt <= '0;
    end else begin
      ecc_sb_cnt <= sb_sum[16] ? 16'hFFFF : sb_sum[15:0];
      ecc_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`else
  assign ecc_sb_cnt = '0;
  assign ecc_drop_cnt = '0;
`endif
endmodule
